// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC and applies control transfers resolved
// in D after the delay-slot fetch completes, plus exception/eret redirects.
//
// Handshake: the fetch at pc_f completes in the cycle imem_ack is high. The
// PC only moves on an "advance" (imem_ack && !d_stall). A target resolved
// before that ack is parked in a pending register until the delay slot is
// acknowledged. exc_req and eret_req are single-cycle commands that take
// effect on the next rising edge, whatever the ack or stall state.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic        d_stall,
    input  logic [31:0] d_pc,
    input  logic        d_is_branch,
    input  logic        d_cond,
    input  logic [15:0] d_br_offset,
    input  logic        d_is_j,
    input  logic [25:0] d_j_index,
    input  logic        d_is_jr,
    input  logic [31:0] d_jr_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        redirect_pending,
    output logic        misalign_f
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] pend_q, pend_d;

    logic        resolve;
    logic        advance;
    logic [31:0] pc4_d;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;

    // Decode the D-stage decision into a single target (jr > j > branch).
    always_comb begin
        resolve   = !d_stall && (d_is_jr || d_is_j || (d_is_branch && d_cond));
        advance   = imem_ack && !d_stall;
        pc4_d     = d_pc + 32'd4;
        br_target = pc4_d + {{14{d_br_offset[15]}}, d_br_offset, 2'b00};
        j_target  = {pc4_d[31:28], d_j_index, 2'b00};
        if (d_is_jr) begin
            target = d_jr_target;
        end else if (d_is_j) begin
            target = j_target;
        end else begin
            target = br_target;
        end
    end

    // Next-state / next-PC selection; CP0 redirects win over everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_f;
        pend_d  = pend_q;
        if (exc_req) begin
            pc_d    = EXC_PC;
            state_d = RUN;
            pend_d  = 32'd0;
        end else if (eret_req) begin
            pc_d    = epc;
            state_d = RUN;
            pend_d  = 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (resolve && advance) begin
                        // Delay slot was the fetch just acked; jump now.
                        pc_d = target;
                    end else if (resolve) begin
                        pend_d  = target;
                        state_d = PEND;
                    end else if (advance) begin
                        pc_d = pc_f + 32'd4;
                    end
                end
                PEND: begin
                    if (advance) begin
                        pc_d = pend_q;
                        if (resolve) begin
                            pend_d = target;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (resolve) begin
                        // Latest resolved target replaces the parked one.
                        pend_d = target;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, PC and pending-target registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_f    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_f    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign redirect_pending = (state_q == PEND);
    assign misalign_f       = (pc_f[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        imem_ack;
    logic        d_stall;
    logic [31:0] d_pc;
    logic        d_is_branch;
    logic        d_cond;
    logic [15:0] d_br_offset;
    logic        d_is_j;
    logic [25:0] d_j_index;
    logic        d_is_jr;
    logic [31:0] d_jr_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        redirect_pending;
    logic        misalign_f;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: fetch PC plus a queue holding at most one parked target.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    pc_redirect_unit #(
        .RESET_PC(RESET_PC),
        .EXC_PC  (EXC_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_ack        (imem_ack),
        .d_stall         (d_stall),
        .d_pc            (d_pc),
        .d_is_branch     (d_is_branch),
        .d_cond          (d_cond),
        .d_br_offset     (d_br_offset),
        .d_is_j          (d_is_j),
        .d_j_index       (d_j_index),
        .d_is_jr         (d_is_jr),
        .d_jr_target     (d_jr_target),
        .exc_req         (exc_req),
        .eret_req        (eret_req),
        .epc             (epc),
        .pc_f            (pc_f),
        .redirect_pending(redirect_pending),
        .misalign_f      (misalign_f)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        imem_ack    = 1'b0;
        d_stall     = 1'b0;
        d_pc        = 32'd0;
        d_is_branch = 1'b0;
        d_cond      = 1'b0;
        d_br_offset = 16'd0;
        d_is_j      = 1'b0;
        d_j_index   = 26'd0;
        d_is_jr     = 1'b0;
        d_jr_target = 32'd0;
        exc_req     = 1'b0;
        eret_req    = 1'b0;
        epc         = 32'd0;
    endtask

    function automatic logic [31:0] model_target();
        logic [31:0] pc4;
        pc4 = d_pc + 32'd4;
        if (d_is_jr) return d_jr_target;
        if (d_is_j) return (pc4 & 32'hF000_0000) | ({6'd0, d_j_index} << 2);
        return pc4 + (32'($signed(d_br_offset)) * 32'd4);
    endfunction

    // One clock: predict from the current inputs, clock the DUT, compare.
    task automatic step();
        logic [31:0] n_pc;
        logic [31:0] n_pend[$];
        logic        res;
        logic        adv;
        logic [31:0] t;
        n_pc   = m_pc;
        n_pend = m_pend;
        res    = !d_stall && (d_is_jr || d_is_j || (d_is_branch && d_cond));
        adv    = imem_ack && !d_stall;
        t      = model_target();
        if (exc_req) begin
            n_pc = EXC_PC;
            n_pend.delete();
        end else if (eret_req) begin
            n_pc = epc;
            n_pend.delete();
        end else if (n_pend.size() != 0) begin
            if (adv) n_pc = n_pend.pop_front();
            if (res) begin
                n_pend.delete();
                n_pend.push_back(t);
            end
        end else begin
            if (res && adv) n_pc = t;
            else if (res) n_pend.push_back(t);
            else if (adv) n_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        m_pc   = n_pc;
        m_pend = n_pend;
        #1;
        check("pc_f", pc_f, m_pc);
        check("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend.size() != 0});
        check("misalign_f", {31'd0, misalign_f}, {31'd0, m_pc[1:0] != 2'b00});
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_pend.delete();
    endtask

    task automatic do_jr(input logic [31:0] tgt, input logic ack);
        clear_inputs();
        d_is_jr     = 1'b1;
        d_jr_target = tgt;
        imem_ack    = ack;
        step();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", pc_f, 32'h0000_3000);
        check("reset_pending", {31'd0, redirect_pending}, 32'd0);
        reset = 1'b1;

        // Sequential fetch.
        imem_ack = 1'b1;
        step(); check("seq1", pc_f, 32'h0000_3004);
        step(); check("seq2", pc_f, 32'h0000_3008);
        step(); check("seq3", pc_f, 32'h0000_300C);

        // Taken branch backwards, then untaken branch.
        clear_inputs();
        d_pc = 32'h0000_3008; d_is_branch = 1'b1; d_cond = 1'b1;
        d_br_offset = 16'hFFFE; imem_ack = 1'b1;
        step(); check("br_taken", pc_f, 32'h0000_3004);
        d_cond = 1'b0;
        step(); check("br_untaken", pc_f, 32'h0000_3008);

        // Jump resolved while the delay-slot fetch is unacknowledged.
        clear_inputs();
        d_is_j = 1'b1; d_pc = 32'h0000_3000; d_j_index = 26'h0000C10;
        repeat (3) step();
        check("pend_flag", {31'd0, redirect_pending}, 32'd1);
        check("pend_hold", pc_f, 32'h0000_3008);
        clear_inputs();
        imem_ack = 1'b1;
        step(); check("pend_apply", pc_f, 32'h0000_3040);
        check("pend_clear", {31'd0, redirect_pending}, 32'd0);

        // Stall masks both resolve and advance.
        clear_inputs();
        d_stall = 1'b1; d_is_jr = 1'b1; d_jr_target = 32'h0000_5000; imem_ack = 1'b1;
        step(); check("stall_hold", pc_f, 32'h0000_3040);
        d_stall = 1'b0;
        step(); check("stall_release", pc_f, 32'h0000_5000);

        // Exception beats eret, ack and a pending redirect.
        do_jr(32'h0000_6000, 1'b0);
        clear_inputs();
        exc_req = 1'b1; eret_req = 1'b1; imem_ack = 1'b1;
        step(); check("exc_pc", pc_f, 32'h0000_4180);
        check("exc_pend", {31'd0, redirect_pending}, 32'd0);
        clear_inputs();
        eret_req = 1'b1; epc = 32'h0000_3024;
        step(); check("eret_pc", pc_f, 32'h0000_3024);

        // Misaligned jr target and PC wrap.
        do_jr(32'h0000_3002, 1'b1);
        check("misalign", {31'd0, misalign_f}, 32'd1);
        do_jr(32'hFFFF_FFFC, 1'b1);
        clear_inputs();
        imem_ack = 1'b1;
        step(); check("wrap", pc_f, 32'h0000_0000);

        // Pending target consumed while a new resolve re-arms pending.
        do_jr(32'h0000_A000, 1'b0);
        do_jr(32'h0000_B000, 1'b1);
        check("pend_chain_pc", pc_f, 32'h0000_A000);
        check("pend_chain_flag", {31'd0, redirect_pending}, 32'd1);
        clear_inputs();
        imem_ack = 1'b1;
        step(); check("pend_chain_next", pc_f, 32'h0000_B000);

        // Asynchronous reset in the middle of PEND.
        do_jr(32'h0000_C000, 1'b0);
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_pc", pc_f, 32'h0000_3000);
        check("async_rst_pend", {31'd0, redirect_pending}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            imem_ack    = ($urandom_range(0, 99) < 60);
            d_stall     = ($urandom_range(0, 99) < 20);
            d_pc        = {16'd0, 14'($urandom()), 2'b00};
            if ($urandom_range(0, 9) == 0) d_pc = {$urandom()} & 32'hFFFF_FFFC;
            d_is_branch = ($urandom_range(0, 99) < 30);
            d_cond      = $urandom_range(0, 1) == 1;
            d_br_offset = 16'($urandom());
            d_is_j      = ($urandom_range(0, 99) < 15);
            d_j_index   = 26'($urandom());
            d_is_jr     = ($urandom_range(0, 99) < 15);
            d_jr_target = $urandom();
            exc_req     = ($urandom_range(0, 99) < 3);
            eret_req    = ($urandom_range(0, 99) < 3);
            epc         = $urandom();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
